// File: rtl/thor2022_mem_req_sched.sv
// Memory request scheduler: round-robin queue writer plus queue-to-dcache drain.
// Optional perf counters: define THOR2022_MRSCHED_PERF_EN.
`timescale 1ns/1ps
module thor2022_mem_req_sched #(
  parameter int RETRY_MAX = 15,
`ifdef THOR2022_MRSCHED_PERF_EN
  parameter int PERF_W    = 32,
`endif
  parameter int REQ_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [REQ_W-1:0] req_i0,
  input  logic [REQ_W-1:0] req_i1,
  output logic [1:0]       req_done,
  output logic             qwr0,
  output logic [REQ_W-1:0] qi0,
  output logic             qwr1,
  output logic [REQ_W-1:0] qi1,
  input  logic             qwr_ack0,
  input  logic             qwr_ack1,
  input  logic             q_valid,
  input  logic [REQ_W-1:0] q_o,
  output logic             q_rd,
  output logic             dc_req,
  output logic [REQ_W-1:0] dc_o,
  input  logic             dc_ack,
`ifdef THOR2022_MRSCHED_PERF_EN
  output logic [PERF_W-1:0] perf_gnt0,
  output logic [PERF_W-1:0] perf_gnt1,
  output logic [PERF_W-1:0] perf_stall,
`endif
  output logic             qfull_stall,
  output logic             busy
);

  typedef enum logic [1:0] {
    W_ARB,
    W_ISSUE,
    W_WAIT
  } wst_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_POP,
    D_SETTLE,
    D_REQ
  } dst_t;

  wst_t       wst;
  dst_t       dst;
  logic       gnt;
  logic       last_grant;
  logic [3:0] retry_cnt;
  logic [3:0] retry_inc;
  logic       arb_gnt;
  logic       wack;

  // both pending: pick the port that did not win last time
  assign arb_gnt = req_valid[1] & (~req_valid[0] | ~last_grant);
  assign wack = gnt ? qwr_ack1 : qwr_ack0;
  assign retry_inc = (retry_cnt == 4'hf) ? retry_cnt
                                         : retry_cnt + 4'd1;

  assign req_done[0] = (wst == W_WAIT) & ~gnt & qwr_ack0;
  assign req_done[1] = (wst == W_WAIT) & gnt & qwr_ack1;
  assign q_rd = (dst == D_POP) & q_valid;
  assign busy = (wst != W_ARB) | (dst != D_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wst         <= W_ARB;
      gnt         <= 1'b0;
      last_grant  <= 1'b1;
      retry_cnt   <= 4'd0;
      qfull_stall <= 1'b0;
      qwr0        <= 1'b0;
      qwr1        <= 1'b0;
      qi0         <= '0;
      qi1         <= '0;
    end else begin
      unique case (wst)
        W_ARB: begin
          if (|req_valid) begin
            gnt <= arb_gnt;
            if (arb_gnt) qi1 <= req_i1;
            else         qi0 <= req_i0;
            qwr0 <= ~arb_gnt;
            qwr1 <= arb_gnt;
            wst  <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          qwr0 <= 1'b0;
          qwr1 <= 1'b0;
          wst  <= W_WAIT;
        end
        W_WAIT: begin
          if (wack) begin
            last_grant  <= gnt;
            retry_cnt   <= 4'd0;
            qfull_stall <= 1'b0;
            wst         <= W_ARB;
          end else begin
            retry_cnt   <= retry_inc;
            qfull_stall <= int'({28'd0, retry_inc}) >= RETRY_MAX;
            qwr0        <= ~gnt;
            qwr1        <= gnt;
            wst         <= W_ISSUE;
          end
        end
        default: wst <= W_ARB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst    <= D_IDLE;
      dc_req <= 1'b0;
      dc_o   <= '0;
    end else begin
      unique case (dst)
        D_IDLE: begin
          if (q_valid) dst <= D_POP;
        end
        D_POP: begin
          if (q_valid) begin
            dc_o <= q_o;
            dst  <= D_SETTLE;
          end else begin
            dst  <= D_IDLE;
          end
        end
        D_SETTLE: begin
          dc_req <= 1'b1;
          dst    <= D_REQ;
        end
        D_REQ: begin
          if (dc_ack) begin
            dc_req <= 1'b0;
            dst    <= D_IDLE;
          end
        end
        default: dst <= D_IDLE;
      endcase
    end
  end

`ifdef THOR2022_MRSCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_gnt0  <= '0;
      perf_gnt1  <= '0;
      perf_stall <= '0;
    end else begin
      if (req_done[0]) perf_gnt0 <= perf_gnt0 + 1'b1;
      if (req_done[1]) perf_gnt1 <= perf_gnt1 + 1'b1;
      if ((wst == W_WAIT) && !wack)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_thor2022_mem_req_sched.sv
// Randomized bench for thor2022_mem_req_sched against a cycle reference model.
// Environment models the request queue, both requesters and the dcache.
`timescale 1ns/1ps
module tb_thor2022_mem_req_sched;
  localparam int RW   = 64;
  localparam int RMAX = 15;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [RW-1:0] req_i0, req_i1;
  logic [1:0]    req_done;
  logic          qwr0, qwr1;
  logic [RW-1:0] qi0, qi1;
  logic          qwr_ack0, qwr_ack1;
  logic          q_valid;
  logic [RW-1:0] q_o;
  logic          q_rd, dc_req, dc_ack;
  logic [RW-1:0] dc_o;
  logic          qfull_stall, busy;
`ifdef THOR2022_MRSCHED_PERF_EN
  logic [31:0]   perf_gnt0, perf_gnt1, perf_stall;
`endif

  always #5 clk = ~clk;

  thor2022_mem_req_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid),
    .req_i0(req_i0), .req_i1(req_i1),
    .req_done(req_done),
    .qwr0(qwr0), .qi0(qi0),
    .qwr1(qwr1), .qi1(qi1),
    .qwr_ack0(qwr_ack0), .qwr_ack1(qwr_ack1),
    .q_valid(q_valid), .q_o(q_o),
    .q_rd(q_rd),
    .dc_req(dc_req), .dc_o(dc_o), .dc_ack(dc_ack),
`ifdef THOR2022_MRSCHED_PERF_EN
    .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1),
    .perf_stall(perf_stall),
`endif
    .qfull_stall(qfull_stall), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  // reference model: write phase 0=arb 1=strobe 2=wait,
  // drain phase 0=idle 1=pop 2=settle 3=request
  int            m_w, m_d, m_retry;
  bit            m_gnt, m_last;
  logic [RW-1:0] m_qi0, m_qi1, m_dco;
  int            m_pg0, m_pg1, m_pst;

  // environment
  bit            pend0, pend1;
  logic [RW-1:0] rd0, rd1;
  bit            due0, due1;
  logic [RW-1:0] wq0, wq1;
  logic [RW-1:0] qmem[$];
  int            qcap, ack_pct, dack_pct, req_pct;

  task automatic model_reset();
    m_w = 0; m_d = 0; m_retry = 0;
    m_gnt = 1'b0; m_last = 1'b1;
    m_qi0 = '0; m_qi1 = '0; m_dco = '0;
    m_pg0 = 0; m_pg1 = 0; m_pst = 0;
    due0 = 1'b0; due1 = 1'b0;
  endtask

  task automatic check_zero();
    chk("rst_qwr0", qwr0, 0);
    chk("rst_qwr1", qwr1, 0);
    chk("rst_done", req_done, 0);
    chk("rst_q_rd", q_rd, 0);
    chk("rst_dc_req", dc_req, 0);
    chk("rst_stall", qfull_stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_qi0", qi0, 0);
    chk("rst_qi1", qi1, 0);
    chk("rst_dc_o", dc_o, 0);
  endtask

  task automatic drive();
    bit ok;
    ok = qmem.size() < qcap;
    qwr_ack0 = due0 ? (ok && $urandom_range(99) < ack_pct)
                    : ($urandom_range(7) == 0);
    ok = qmem.size() < qcap;
    qwr_ack1 = due1 ? (ok && $urandom_range(99) < ack_pct)
                    : ($urandom_range(7) == 0);
    if (!pend0 && $urandom_range(99) < req_pct) begin
      pend0 = 1'b1; rd0 = {$urandom, $urandom};
    end
    if (!pend1 && $urandom_range(99) < req_pct) begin
      pend1 = 1'b1; rd1 = {$urandom, $urandom};
    end
    req_valid = {pend1, pend0};
    req_i0 = rd0;
    req_i1 = rd1;
    q_valid = qmem.size() > 0;
    q_o = q_valid ? qmem[0] : {$urandom, $urandom};
    dc_ack = dc_req && ($urandom_range(99) < dack_pct);
  endtask

  task automatic compare();
    logic [1:0] e_done;
    e_done[0] = (m_w == 2) && !m_gnt && qwr_ack0;
    e_done[1] = (m_w == 2) && m_gnt && qwr_ack1;
    chk("qwr0", qwr0, (m_w == 1) && !m_gnt);
    chk("qwr1", qwr1, (m_w == 1) && m_gnt);
    chk("qi0", qi0, m_qi0);
    chk("qi1", qi1, m_qi1);
    chk("req_done", req_done, e_done);
    chk("qfull_stall", qfull_stall, m_retry >= RMAX);
    chk("q_rd", q_rd, (m_d == 1) && q_valid);
    chk("dc_req", dc_req, m_d == 3);
    chk("dc_o", dc_o, m_dco);
    chk("busy", busy, (m_w != 0) || (m_d != 0));
`ifdef THOR2022_MRSCHED_PERF_EN
    chk("perf_gnt0", perf_gnt0, m_pg0);
    chk("perf_gnt1", perf_gnt1, m_pg1);
    chk("perf_stall", perf_stall, m_pst);
`endif
  endtask

  // queue and requesters react to what the DUT actually did
  task automatic env_sample();
    if (due0 && qwr_ack0) qmem.push_back(wq0);
    if (due1 && qwr_ack1) qmem.push_back(wq1);
    if (q_rd && qmem.size() > 0) void'(qmem.pop_front());
    due0 = qwr0; wq0 = qi0;
    due1 = qwr1; wq1 = qi1;
    if (req_done[0]) pend0 = 1'b0;
    if (req_done[1]) pend1 = 1'b0;
  endtask

  task automatic model_step();
    bit ack;
    case (m_w)
      0: if (req_valid != 2'b00) begin
        m_gnt = (req_valid == 2'b11) ? !m_last : req_valid[1];
        if (m_gnt) m_qi1 = req_i1;
        else       m_qi0 = req_i0;
        m_w = 1;
      end
      1: m_w = 2;
      default: begin
        ack = m_gnt ? qwr_ack1 : qwr_ack0;
        if (ack) begin
          if (m_gnt) m_pg1++;
          else       m_pg0++;
          m_last = m_gnt; m_retry = 0; m_w = 0;
        end else begin
          m_pst++;
          if (m_retry < 15) m_retry++;
          m_w = 1;
        end
      end
    endcase
    case (m_d)
      0: if (q_valid) m_d = 1;
      1: if (q_valid) begin m_dco = q_o; m_d = 2; end
         else m_d = 0;
      2: m_d = 3;
      default: if (dc_ack) m_d = 0;
    endcase
  endtask

  task automatic knobs(input int cyc);
    ack_pct = 70; dack_pct = 40; qcap = 4; req_pct = 50;
    if (cyc >= 800 && cyc < 900) ack_pct = 0;
    if (cyc >= 900 && cyc < 1200) begin
      ack_pct = 100; dack_pct = 90; qcap = 8; req_pct = 100;
    end
    if (cyc >= 1400 && cyc < 2000) begin
      ack_pct = 30; dack_pct = 20; qcap = 2;
    end
    if (cyc >= 2000 && cyc < 2080) ack_pct = 0;
  endtask

  initial begin
    int rst_at;
    rst = 1'b1;
    req_valid = '0; req_i0 = '0; req_i1 = '0;
    qwr_ack0 = 0; qwr_ack1 = 0; q_valid = 0;
    q_o = '0; dc_ack = 0;
    pend0 = 0; pend1 = 0; rd0 = '0; rd1 = '0;
    wq0 = '0; wq1 = '0;
    model_reset();
    #2 check_zero();
    rst_at = 1200;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      knobs(cyc);
      drive();
      if (cyc >= rst_at &&
          ((m_w == 2 && m_d == 3) || cyc >= rst_at + 300)) begin
        #2 rst = 1'b1;
        #1 check_zero();
        @(negedge clk);
        model_reset();
        pend0 = 1'b1; pend1 = 1'b1;
        rst_at = (cyc < 2400) ? 2500 : NCYC;
        continue;
      end
      @(negedge clk);
      compare();
      env_sample();
      model_step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
